alu_reservation_station: RTL and testbench
==========================================

Name: alu_reservation_station

Overview:
- Reservation station for the ALU/CMP functional unit. Sits between rename/dispatch and the ALU/CMP FU, and feeds that FU's input bundle.
- Holds up to NUM_ENTRIES dispatched instructions and tracks source-operand readiness by snooping the CDB.
- Each cycle it offers the oldest entry whose two sources are both ready. The FU reads the physical register file in the issue cycle and writes back on the CDB one cycle later.

Parameters:
- NUM_ENTRIES, 8: station depth; power of two, at least 2.
- PREG_IDX_W, 6: physical register index width. Physical register 0 is always ready.
- PAYLOAD_W, 128: width of the opaque instruction-info bundle. It is carried unmodified.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- dispatch_valid  in  1  dispatch offers an instruction
- dispatch_ready  out  1  a free entry exists
- dispatch_payload  in  PAYLOAD_W  instruction info
- dispatch_ps1  in  PREG_IDX_W  source 1 physical register
- dispatch_ps1_rdy  in  1  source 1 already available
- dispatch_ps2  in  PREG_IDX_W  source 2 physical register
- dispatch_ps2_rdy  in  1  source 2 already available
- dispatch_pd  in  PREG_IDX_W  destination physical register
- cdb_valid  in  1  a result is broadcast this cycle
- cdb_pd  in  PREG_IDX_W  destination tag of the broadcast result
- flush  in  1  branch mispredict; squash all entries
- issue_valid  out  1  an entry is offered to the FU
- issue_ready  in  1  FU accepts the offered entry
- issue_payload  out  PAYLOAD_W  offered instruction info
- issue_ps1  out  PREG_IDX_W  register-file read index, port 1
- issue_ps2  out  PREG_IDX_W  register-file read index, port 2
- issue_pd  out  PREG_IDX_W  destination tag
- occupancy  out  $clog2(NUM_ENTRIES)+1  number of valid entries

Behaviour:
- Reset (rst low, asynchronous):
  - All entries invalid; age state cleared.
  - issue_valid=0, occupancy=0, dispatch_ready=1.
  - Payload and tag outputs are don't-care while issue_valid=0.
- Entry state: valid, payload, ps1, ps2, pd, rdy1, rdy2, plus an age matrix (NUM_ENTRIES x NUM_ENTRIES bits; bit[i][j]=1 means entry i is older than j).
- dispatch_ready:
  - Equals occupancy < NUM_ENTRIES, taken from registered state only.
  - A slot freed by an issue in the same cycle is not reusable until the next cycle.
- Dispatch:
  - On dispatch_valid && dispatch_ready && !flush, the lowest-index free entry is written at the clock edge.
  - rdyN = dispatch_psN_rdy OR (psN==0) OR (cdb_valid && cdb_pd==psN). The last term is the same-cycle CDB bypass.
  - Age row/column updated so the new entry is youngest.
- Wakeup:
  - Each cycle with cdb_valid, every valid entry with psN==cdb_pd sets rdyN at the edge.
  - A woken entry is first eligible for issue in the following cycle; there is no same-cycle wakeup-to-issue.
- Issue select:
  - Combinational from registered state.
  - Eligible entries are those with valid && rdy1 && rdy2. issue_valid=1 if any entry is eligible and flush=0.
  - The oldest eligible entry per the age matrix drives the issue_* outputs.
- Issue handshake:
  - On issue_valid && issue_ready, the selected entry is invalidated at the edge.
  - If issue_ready=0, nothing is freed. The next cycle may offer a different, older, newly-woken entry; the FU must not assume the payload stays stable.
- Latency:
  - Dispatch with both sources ready at edge N gives issue_valid=1 in cycle N+1.
  - Dispatch waiting on a tag broadcast in cycle M gives issue in cycle M+1 at the earliest.
- occupancy:
  - Incremented on accepted dispatch, decremented on accepted issue.
  - Unchanged when both happen in the same cycle.
- Flush:
  - When flush=1, issue_valid=0 and dispatch is ignored that cycle.
  - All entries are invalidated at the edge and occupancy becomes 0.
  - The CDB in the flush cycle is ignored.
  - Full and empty conditions resolve normally from the next cycle.
- Full: dispatch_valid is held off by dispatch_ready=0. The station never overwrites a valid entry.
- Empty: issue_valid=0 and occupancy=0.
- Reset mid-operation: everything is cleared immediately, identical to the reset state.
- A CDB broadcast with cdb_pd==0 wakes nothing extra; register 0 is already ready.

Test Plan:
- Reset, then dispatch {ps1=3 rdy, ps2=4 rdy, pd=10} at edge 1 with issue_ready=1 -> issue_valid=1 with issue_pd=10 in cycle 2, occupancy returns to 0 at edge 2.
- Dispatch A {ps1=5 not ready, pd=11}, then B {both ready, pd=12}, then cdb_pd=5 -> B issues first. A issues the cycle after the cdb_pd=5 broadcast, never in the same cycle as it.
- Fill 8 entries whose sources are all unready (ps1=20) with issue_ready=0 -> dispatch_ready=0 and occupancy=8. Broadcast cdb_pd=20 -> entries issue oldest-first (pd order 0..7), one per cycle, once issue_ready=1.
- Dispatch {ps1=7 not ready} in the same cycle that cdb_pd=7 is valid -> entry stored ready, issues next cycle.
- Station holding 5 entries, assert flush together with dispatch_valid=1 -> issue_valid=0 that cycle, occupancy=0 next cycle, the dispatched instruction is absent.
- Full station, issue accepted and dispatch_valid=1 in the same cycle -> dispatch not accepted, occupancy=7. Dispatch accepted next cycle, occupancy=8.

Source files
------------

// File: rtl/alu_reservation_station_if.sv
// Dispatch, CDB, flush and issue bundle of the ALU/CMP reservation station.
interface alu_reservation_station_if #(
    parameter int NUM_ENTRIES = 8,
    parameter int PREG_IDX_W  = 6,
    parameter int PAYLOAD_W   = 128
);
    localparam int OCC_W = $clog2(NUM_ENTRIES) + 1;

    // dispatch side
    logic                  dispatch_valid;
    logic                  dispatch_ready;
    logic [PAYLOAD_W-1:0]  dispatch_payload;
    logic [PREG_IDX_W-1:0] dispatch_ps1;
    logic                  dispatch_ps1_rdy;
    logic [PREG_IDX_W-1:0] dispatch_ps2;
    logic                  dispatch_ps2_rdy;
    logic [PREG_IDX_W-1:0] dispatch_pd;

    // result broadcast and squash
    logic                  cdb_valid;
    logic [PREG_IDX_W-1:0] cdb_pd;
    logic                  flush;

    // issue side towards the FU
    logic                  issue_valid;
    logic                  issue_ready;
    logic [PAYLOAD_W-1:0]  issue_payload;
    logic [PREG_IDX_W-1:0] issue_ps1;
    logic [PREG_IDX_W-1:0] issue_ps2;
    logic [PREG_IDX_W-1:0] issue_pd;

    logic [OCC_W-1:0]      occupancy;

    // environment: dispatch stage, CDB, flush source and FU
    modport master (
        output dispatch_valid, dispatch_payload, dispatch_ps1, dispatch_ps1_rdy,
               dispatch_ps2, dispatch_ps2_rdy, dispatch_pd,
               cdb_valid, cdb_pd, flush, issue_ready,
        input  dispatch_ready, issue_valid, issue_payload, issue_ps1, issue_ps2,
               issue_pd, occupancy
    );

    // the reservation station itself
    modport slave (
        input  dispatch_valid, dispatch_payload, dispatch_ps1, dispatch_ps1_rdy,
               dispatch_ps2, dispatch_ps2_rdy, dispatch_pd,
               cdb_valid, cdb_pd, flush, issue_ready,
        output dispatch_ready, issue_valid, issue_payload, issue_ps1, issue_ps2,
               issue_pd, occupancy
    );
endinterface

// File: rtl/alu_reservation_station.sv
// ALU/CMP reservation station: holds dispatched instructions, wakes sources
// from the CDB and offers the oldest fully-ready entry to the FU each cycle.
module alu_reservation_station #(
    parameter int NUM_ENTRIES = 8,
    parameter int PREG_IDX_W  = 6,
    parameter int PAYLOAD_W   = 128
) (
    input  logic                          clk,
    input  logic                          rst,
    alu_reservation_station_if.slave      rs_if
);
    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int OCC_W = IDX_W + 1;

    // entry state
    logic [NUM_ENTRIES-1:0] valid_q, valid_d;
    logic [NUM_ENTRIES-1:0] rdy1_q, rdy1_d;
    logic [NUM_ENTRIES-1:0] rdy2_q, rdy2_d;
    logic [NUM_ENTRIES-1:0] age_q [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] age_d [NUM_ENTRIES];
    logic [PAYLOAD_W-1:0]   payload_q [NUM_ENTRIES];
    logic [PREG_IDX_W-1:0]  ps1_q [NUM_ENTRIES];
    logic [PREG_IDX_W-1:0]  ps2_q [NUM_ENTRIES];
    logic [PREG_IDX_W-1:0]  pd_q  [NUM_ENTRIES];
    logic [OCC_W-1:0]       occ_q, occ_d;

    // combinational control
    logic [NUM_ENTRIES-1:0] eligible_s;
    logic [NUM_ENTRIES-1:0] sel_oh_s;
    logic [IDX_W-1:0]       sel_idx_s;
    logic [IDX_W-1:0]       free_idx_s;
    logic                   dispatch_ready_s;
    logic                   disp_fire_s;
    logic                   issue_valid_s;
    logic                   issue_fire_s;
    logic                   disp_rdy1_s;
    logic                   disp_rdy2_s;

    // Oldest-ready select: an eligible entry wins if it is older than every
    // other eligible entry; the age matrix is a total order over valid entries.
    always_comb begin
        eligible_s = valid_q & rdy1_q & rdy2_q;
        sel_oh_s   = '0;
        sel_idx_s  = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            sel_oh_s[i] = eligible_s[i];
            for (int j = 0; j < NUM_ENTRIES; j++) begin
                if ((j != i) && eligible_s[j] && !age_q[i][j]) begin
                    sel_oh_s[i] = 1'b0;
                end else begin
                    sel_oh_s[i] = sel_oh_s[i];
                end
            end
        end
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (sel_oh_s[i]) begin
                sel_idx_s = IDX_W'(i);
            end else begin
                sel_idx_s = sel_idx_s;
            end
        end
    end

    // Lowest-index free slot, scanned downward so the lowest index wins.
    always_comb begin
        free_idx_s = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_idx_s = IDX_W'(i);
            end else begin
                free_idx_s = free_idx_s;
            end
        end
    end

    // Handshake qualifiers and dispatch-time readiness including CDB bypass.
    always_comb begin
        dispatch_ready_s = (occ_q < OCC_W'(NUM_ENTRIES));
        disp_fire_s      = rs_if.dispatch_valid && dispatch_ready_s && !rs_if.flush;
        issue_valid_s    = (|eligible_s) && !rs_if.flush;
        issue_fire_s     = issue_valid_s && rs_if.issue_ready;
        disp_rdy1_s      = rs_if.dispatch_ps1_rdy
                         || (rs_if.dispatch_ps1 == PREG_IDX_W'(0))
                         || (rs_if.cdb_valid && (rs_if.cdb_pd == rs_if.dispatch_ps1));
        disp_rdy2_s      = rs_if.dispatch_ps2_rdy
                         || (rs_if.dispatch_ps2 == PREG_IDX_W'(0))
                         || (rs_if.cdb_valid && (rs_if.cdb_pd == rs_if.dispatch_ps2));
    end

    // Next state of valid/ready bits, age matrix and occupancy. Wakeup is
    // applied first so a dispatch into a free slot overrides stale bits.
    always_comb begin
        valid_d = valid_q;
        rdy1_d  = rdy1_q;
        rdy2_d  = rdy2_q;
        age_d   = age_q;
        occ_d   = occ_q;
        if (rs_if.flush) begin
            valid_d = '0;
            occ_d   = '0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (rs_if.cdb_valid && valid_q[i] && (ps1_q[i] == rs_if.cdb_pd)) begin
                    rdy1_d[i] = 1'b1;
                end else begin
                    rdy1_d[i] = rdy1_d[i];
                end
                if (rs_if.cdb_valid && valid_q[i] && (ps2_q[i] == rs_if.cdb_pd)) begin
                    rdy2_d[i] = 1'b1;
                end else begin
                    rdy2_d[i] = rdy2_d[i];
                end
            end
            if (issue_fire_s) begin
                valid_d[sel_idx_s] = 1'b0;
            end else begin
                valid_d = valid_d;
            end
            if (disp_fire_s) begin
                valid_d[free_idx_s] = 1'b1;
                rdy1_d[free_idx_s]  = disp_rdy1_s;
                rdy2_d[free_idx_s]  = disp_rdy2_s;
                age_d[free_idx_s]   = '0;
                for (int j = 0; j < NUM_ENTRIES; j++) begin
                    if (IDX_W'(j) != free_idx_s) begin
                        age_d[j][free_idx_s] = 1'b1;
                    end else begin
                        age_d[j][free_idx_s] = 1'b0;
                    end
                end
            end else begin
                valid_d = valid_d;
            end
            case ({disp_fire_s, issue_fire_s})
                2'b10:   occ_d = occ_q + OCC_W'(1);
                2'b01:   occ_d = occ_q - OCC_W'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            rdy1_q  <= '0;
            rdy2_q  <= '0;
            occ_q   <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            rdy1_q  <= rdy1_d;
            rdy2_q  <= rdy2_d;
            occ_q   <= occ_d;
            age_q   <= age_d;
        end
    end

    // Entry payload and tag storage, written only on an accepted dispatch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                payload_q[i] <= '0;
                ps1_q[i]     <= '0;
                ps2_q[i]     <= '0;
                pd_q[i]      <= '0;
            end
        end else if (disp_fire_s) begin
            payload_q[free_idx_s] <= rs_if.dispatch_payload;
            ps1_q[free_idx_s]     <= rs_if.dispatch_ps1;
            ps2_q[free_idx_s]     <= rs_if.dispatch_ps2;
            pd_q[free_idx_s]      <= rs_if.dispatch_pd;
        end else begin
            payload_q <= payload_q;
        end
    end

    assign rs_if.dispatch_ready = dispatch_ready_s;
    assign rs_if.issue_valid    = issue_valid_s;
    assign rs_if.issue_payload  = payload_q[sel_idx_s];
    assign rs_if.issue_ps1      = ps1_q[sel_idx_s];
    assign rs_if.issue_ps2      = ps2_q[sel_idx_s];
    assign rs_if.issue_pd       = pd_q[sel_idx_s];
    assign rs_if.occupancy      = occ_q;
endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed, table-driven bench for the ALU reservation station.
module tb_alu_reservation_station;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    alu_reservation_station_if bus ();

    alu_reservation_station dut (
        .clk   (clk),
        .rst   (rst),
        .rs_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       dv;
        logic [5:0] ps1;
        logic       r1;
        logic [5:0] ps2;
        logic       r2;
        logic [5:0] pd;
        logic       cv;
        logic [5:0] cpd;
        logic       fl;
        logic       ir;
        logic       e_iv;
        logic [5:0] e_pd;
        int         e_occ;
        logic       e_dr;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [127:0] mk_payload(input logic [5:0] pd);
        return {8'hC3, {19{pd}}, 6'h2A};
    endfunction

    function automatic vec_t mkv(input logic dv, input logic [5:0] ps1, input logic r1,
                                 input logic [5:0] ps2, input logic r2, input logic [5:0] pd,
                                 input logic cv, input logic [5:0] cpd, input logic fl,
                                 input logic ir, input logic e_iv, input logic [5:0] e_pd,
                                 input int e_occ, input logic e_dr);
        vec_t v;
        v.dv = dv; v.ps1 = ps1; v.r1 = r1; v.ps2 = ps2; v.r2 = r2; v.pd = pd;
        v.cv = cv; v.cpd = cpd; v.fl = fl; v.ir = ir;
        v.e_iv = e_iv; v.e_pd = e_pd; v.e_occ = e_occ; v.e_dr = e_dr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic dv, input logic [5:0] ps1, input logic r1,
                         input logic [5:0] ps2, input logic r2, input logic [5:0] pd,
                         input logic cv, input logic [5:0] cpd, input logic fl, input logic ir);
        bus.dispatch_valid   = dv;
        bus.dispatch_ps1     = ps1;
        bus.dispatch_ps1_rdy = r1;
        bus.dispatch_ps2     = ps2;
        bus.dispatch_ps2_rdy = r2;
        bus.dispatch_pd      = pd;
        bus.dispatch_payload = mk_payload(pd);
        bus.cdb_valid        = cv;
        bus.cdb_pd           = cpd;
        bus.flush            = fl;
        bus.issue_ready      = ir;
    endtask

    task automatic idle(input logic ir);
        drive(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, ir);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        idle(1'b0);

        // single-cycle latency
        vecs.push_back(mkv(0, 0,0, 0,0, 0,  0,0, 0,0, 0,0, 0,1));
        vecs.push_back(mkv(1, 3,1, 4,1, 10, 0,0, 0,1, 0,0, 0,1));
        vecs.push_back(mkv(0, 0,0, 0,0, 0,  0,0, 0,1, 1,10,1,1));
        vecs.push_back(mkv(0, 0,0, 0,0, 0,  0,0, 0,1, 0,0, 0,1));
        // ready B overtakes waiting A; A never issues in its wakeup cycle
        vecs.push_back(mkv(1, 5,0, 0,0, 11, 0,0, 0,0, 0,0, 0,1));
        vecs.push_back(mkv(1, 1,1, 2,1, 12, 0,0, 0,0, 0,0, 1,1));
        vecs.push_back(mkv(0, 0,0, 0,0, 0,  0,0, 0,1, 1,12,2,1));
        vecs.push_back(mkv(0, 0,0, 0,0, 0,  1,5, 0,1, 0,0, 1,1));
        vecs.push_back(mkv(0, 0,0, 0,0, 0,  0,0, 0,1, 1,11,1,1));
        vecs.push_back(mkv(0, 0,0, 0,0, 0,  0,0, 0,1, 0,0, 0,1));
        // same-cycle CDB bypass at dispatch
        vecs.push_back(mkv(1, 7,0, 8,1, 13, 1,7, 0,1, 0,0, 0,1));
        vecs.push_back(mkv(0, 0,0, 0,0, 0,  0,0, 0,1, 1,13,1,1));
        vecs.push_back(mkv(0, 0,0, 0,0, 0,  0,0, 0,1, 0,0, 0,1));
        // broadcast of register 0 wakes nothing
        vecs.push_back(mkv(1, 9,0, 9,0, 14, 0,0, 0,1, 0,0, 0,1));
        vecs.push_back(mkv(0, 0,0, 0,0, 0,  1,0, 0,1, 0,0, 1,1));
        vecs.push_back(mkv(0, 0,0, 0,0, 0,  0,0, 0,1, 0,0, 1,1));
        vecs.push_back(mkv(0, 0,0, 0,0, 0,  1,9, 0,1, 0,0, 1,1));
        vecs.push_back(mkv(0, 0,0, 0,0, 0,  0,0, 0,1, 1,14,1,1));
        vecs.push_back(mkv(0, 0,0, 0,0, 0,  0,0, 0,1, 0,0, 0,1));
        // flush with five entries and a concurrent dispatch
        vecs.push_back(mkv(1, 1,1, 2,1, 20, 0,0, 0,0, 0,0, 0,1));
        vecs.push_back(mkv(1, 1,1, 2,1, 21, 0,0, 0,0, 1,20,1,1));
        vecs.push_back(mkv(1, 1,1, 2,1, 22, 0,0, 0,0, 1,20,2,1));
        vecs.push_back(mkv(1, 1,1, 2,1, 23, 0,0, 0,0, 1,20,3,1));
        vecs.push_back(mkv(1, 1,1, 2,1, 24, 0,0, 0,0, 1,20,4,1));
        vecs.push_back(mkv(1, 1,1, 2,1, 25, 0,0, 1,1, 0,0, 5,1));
        vecs.push_back(mkv(0, 0,0, 0,0, 0,  0,0, 0,1, 0,0, 0,1));
        // age beats index: W reuses slot 1 but is younger than Z in slot 2
        vecs.push_back(mkv(1, 30,0, 0,0, 26, 0,0, 0,0, 0,0, 0,1));
        vecs.push_back(mkv(1, 1,1, 2,1, 27, 0,0,  0,1, 0,0, 1,1));
        vecs.push_back(mkv(1, 1,1, 2,1, 28, 0,0,  0,1, 1,27,2,1));
        vecs.push_back(mkv(1, 1,1, 2,1, 29, 0,0,  0,0, 1,28,2,1));
        vecs.push_back(mkv(0, 0,0, 0,0, 0,  1,30, 0,0, 1,28,3,1));
        vecs.push_back(mkv(0, 0,0, 0,0, 0,  0,0,  0,1, 1,26,3,1));
        vecs.push_back(mkv(0, 0,0, 0,0, 0,  0,0,  0,1, 1,28,2,1));
        vecs.push_back(mkv(0, 0,0, 0,0, 0,  0,0,  0,1, 1,29,1,1));
        vecs.push_back(mkv(0, 0,0, 0,0, 0,  0,0,  0,0, 0,0, 0,1));

        repeat (3) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].dv, vecs[i].ps1, vecs[i].r1, vecs[i].ps2, vecs[i].r2, vecs[i].pd,
                  vecs[i].cv, vecs[i].cpd, vecs[i].fl, vecs[i].ir);
            #1;
            chk($sformatf("row%0d issue_valid", i), 128'(bus.issue_valid), 128'(vecs[i].e_iv));
            if (vecs[i].e_iv) begin
                chk($sformatf("row%0d issue_pd", i), 128'(bus.issue_pd), 128'(vecs[i].e_pd));
                chk($sformatf("row%0d issue_payload", i), bus.issue_payload, mk_payload(vecs[i].e_pd));
            end
            chk($sformatf("row%0d occupancy", i), 128'(bus.occupancy), 128'(vecs[i].e_occ));
            chk($sformatf("row%0d dispatch_ready", i), 128'(bus.dispatch_ready), 128'(vecs[i].e_dr));
        end

        // fill with eight waiting entries, then drain oldest-first
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            drive(1'b1, 6'd20, 1'b0, 6'd0, 1'b0, 6'(k), 1'b0, 6'd0, 1'b0, 1'b0);
        end
        @(negedge clk);
        idle(1'b0);
        #1;
        chk("fill occupancy", 128'(bus.occupancy), 128'd8);
        chk("fill dispatch_ready", 128'(bus.dispatch_ready), 128'd0);
        chk("fill issue_valid", 128'(bus.issue_valid), 128'd0);
        @(negedge clk);
        drive(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b1, 6'd20, 1'b0, 1'b0);
        #1;
        chk("wake cycle issue_valid", 128'(bus.issue_valid), 128'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            idle(1'b1);
            #1;
            chk($sformatf("drain%0d issue_valid", k), 128'(bus.issue_valid), 128'd1);
            chk($sformatf("drain%0d issue_pd", k), 128'(bus.issue_pd), 128'(k));
            chk($sformatf("drain%0d issue_ps1", k), 128'(bus.issue_ps1), 128'd20);
            chk($sformatf("drain%0d issue_ps2", k), 128'(bus.issue_ps2), 128'd0);
            chk($sformatf("drain%0d occupancy", k), 128'(bus.occupancy), 128'(8 - k));
        end
        @(negedge clk);
        idle(1'b0);
        #1;
        chk("drained occupancy", 128'(bus.occupancy), 128'd0);
        chk("drained issue_valid", 128'(bus.issue_valid), 128'd0);

        // full station: slot freed by issue is not reusable in the same cycle
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            drive(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 6'(40 + k), 1'b0, 6'd0, 1'b0, 1'b0);
        end
        @(negedge clk);
        drive(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 6'd48, 1'b0, 6'd0, 1'b0, 1'b1);
        #1;
        chk("full dispatch_ready", 128'(bus.dispatch_ready), 128'd0);
        chk("full occupancy", 128'(bus.occupancy), 128'd8);
        chk("full issue_pd", 128'(bus.issue_pd), 128'd40);
        @(negedge clk);
        drive(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 6'd48, 1'b0, 6'd0, 1'b0, 1'b0);
        #1;
        chk("after issue occupancy", 128'(bus.occupancy), 128'd7);
        chk("after issue dispatch_ready", 128'(bus.dispatch_ready), 128'd1);
        @(negedge clk);
        idle(1'b0);
        #1;
        chk("refill occupancy", 128'(bus.occupancy), 128'd8);
        chk("refill dispatch_ready", 128'(bus.dispatch_ready), 128'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            idle(1'b1);
            #1;
            chk($sformatf("full drain%0d issue_pd", k), 128'(bus.issue_pd), 128'(41 + k));
        end

        // asynchronous reset in the middle of operation
        @(negedge clk);
        drive(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 6'd50, 1'b0, 6'd0, 1'b0, 1'b0);
        @(negedge clk);
        idle(1'b0);
        #1;
        chk("pre-reset occupancy", 128'(bus.occupancy), 128'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("async reset occupancy", 128'(bus.occupancy), 128'd0);
        chk("async reset issue_valid", 128'(bus.issue_valid), 128'd0);
        chk("async reset dispatch_ready", 128'(bus.dispatch_ready), 128'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
